// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between a UART receiver/transmitter pair and a combinational ALU:
// collects A, B and opcode bytes, latches the ALU result and hands it to the transmitter.
module uart_alu_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_overrun
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    TX_START,
    TX_WAIT
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   rx_prev;
  logic                   tx_prev;
  logic                   rx_evt;
  logic                   tx_evt;

  // Rising-edge detection so a done level held high is consumed only once
  assign rx_evt = i_rx_done & ~rx_prev;
  assign tx_evt = i_tx_done & ~tx_prev;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= WAIT_A;
      cnt        <= '0;
      rx_prev    <= 1'b0;
      tx_prev    <= 1'b0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      rx_prev    <= i_rx_done;
      tx_prev    <= i_tx_done;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;

      case (state)
        WAIT_A: begin
          if (rx_evt) begin
            o_alu_a <= i_rx_data;
            cnt     <= '0;
            o_busy  <= 1'b1;
            state   <= WAIT_B;
          end
        end

        // A byte arriving on the last allowed cycle still beats the timeout
        WAIT_B: begin
          if (rx_evt) begin
            o_alu_b <= i_rx_data;
            cnt     <= '0;
            state   <= WAIT_OP;
          end else if (cnt == CNT_LAST) begin
            o_timeout <= 1'b1;
            cnt       <= '0;
            o_busy    <= 1'b0;
            state     <= WAIT_A;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end

        WAIT_OP: begin
          if (rx_evt) begin
            o_alu_op <= i_rx_data[OP_WIDTH-1:0];
            cnt      <= '0;
            state    <= EXEC;
          end else if (cnt == CNT_LAST) begin
            o_timeout <= 1'b1;
            cnt       <= '0;
            o_busy    <= 1'b0;
            state     <= WAIT_A;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end

        // Operands have been stable for a full cycle, so the ALU output has settled
        EXEC: begin
          o_tx_data <= i_alu_result;
          o_overrun <= rx_evt;
          state     <= TX_START;
        end

        TX_START: begin
          o_tx_start <= 1'b1;
          o_overrun  <= rx_evt;
          state      <= TX_WAIT;
        end

        TX_WAIT: begin
          o_overrun <= rx_evt;
          if (tx_evt) begin
            o_busy <= 1'b0;
            state  <= WAIT_A;
          end
        end

        default: begin
          o_busy <= 1'b0;
          state  <= WAIT_A;
        end
      endcase
    end
  end

endmodule
